fx2_ep2_reader: RTL and testbench

FX2_EP2_READER -- requirements
Module: fx2_ep2_reader

---
 rtl/fx2_pkg.sv | 21 ++
 rtl/fx2_ep2_reader.sv | 105 ++++++++++
 tb/tb_fx2_ep2_reader.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 slave-FIFO interface blocks: reader FSM
// state encoding, endpoint FIFO select values and the default flag-settle time.
package fx2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETUP,
    RD,
    HOLD,
    WAITF
  } state_t;

  // FIFOADR values selecting the EP2 (OUT) and EP6 (IN) FIFOs.
  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP6_ADDR = 2'b10;

  // Idle cycles after a read before FLAGA reflects the pop.
  localparam int FLAG_WAIT_DEFAULT = 1;

endpackage

// File: rtl/fx2_ep2_reader.sv
// EP2 OUT-endpoint reader for the FX2 slave FIFO. Arbitrates for the shared
// FD bus, pulses SLRD once per word, and presents each word on a
// valid/ready stream.
// Optional build macro FX2_RD_WORDCNT_EN enables the accepted-word counter;
// without it word_cnt is tied to zero.
module fx2_ep2_reader
  import fx2_pkg::*;
#(
  parameter logic [1:0] EP_ADDR   = EP2_ADDR,
  parameter int         FLAG_WAIT = FLAG_WAIT_DEFAULT
) (
  input  logic        clk_fast,
  input  logic        n_rst,
  input  logic [15:0] fdata_i,
  output logic [1:0]  faddr,
  output logic        slrd_n,
  output logic        sloe_n,
  input  logic        flaga_n,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] word_cnt,
  output logic        busy
);

  localparam logic [2:0] WAIT_LAST = 3'(FLAG_WAIT - 1);

  state_t     state;
  state_t     state_next;
  logic [2:0] wait_cnt;
  logic       accept;

  assign accept = out_valid && out_ready;

  // Bus-facing strobes decode straight from state, so reset forces them
  // together with the state register.
  assign faddr   = EP_ADDR;
  assign bus_req = (state != IDLE);
  assign busy    = (state != IDLE);
  assign slrd_n  = (state != RD);
  assign sloe_n  = !(state inside {SETUP, RD, HOLD, WAITF});

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_fast or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a read entered in RD always runs through HOLD.
  // NOTE: state_next gets a default first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (flaga_n) state_next = REQ;
      REQ: begin
        if (!flaga_n)     state_next = IDLE;
        else if (bus_gnt) state_next = SETUP;
      end
      SETUP: state_next = (bus_gnt && flaga_n) ? RD : IDLE;
      RD:    state_next = HOLD;
      HOLD:  if (out_ready) state_next = bus_gnt ? WAITF : IDLE;
      WAITF: begin
        if (!bus_gnt)                   state_next = IDLE;
        else if (wait_cnt == WAIT_LAST) state_next = flaga_n ? RD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Flag-settle counter: runs only while in WAITF, restarts on every entry.
  always_ff @(posedge clk_fast or negedge n_rst) begin
    if (!n_rst)              wait_cnt <= '0;
    else if (state == WAITF) wait_cnt <= wait_cnt + 3'd1;
    else                     wait_cnt <= '0;
  end

  // Output word register: captured on the edge that ends RD, held through HOLD.
  always_ff @(posedge clk_fast or negedge n_rst) begin
    if (!n_rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (state == RD) begin
      out_data  <= fdata_i;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FX2_RD_WORDCNT_EN
  // Accepted-word counter, wraps naturally at 20 bits.
  always_ff @(posedge clk_fast or negedge n_rst) begin
    if (!n_rst)      word_cnt <= '0;
    else if (accept) word_cnt <= word_cnt + 20'd1;
  end
`else
  assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_fx2_ep2_reader.sv
// Self-checking bench for fx2_ep2_reader: a cycle-by-cycle vector table for
// the FSM transitions, then an FX2 FIFO model driving multi-word sequences.
module tb_fx2_ep2_reader;

`ifdef FX2_RD_WORDCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_fast;
  logic        n_rst;
  logic [15:0] fdata_i;
  logic [1:0]  faddr;
  logic        slrd_n;
  logic        sloe_n;
  logic        flaga_n;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] word_cnt;
  logic        busy;

  // Stimulus sources: table-driven or from the FIFO model.
  logic        model_en;
  logic        t_flaga;
  logic [15:0] t_data;
  logic        m_flaga;
  logic [15:0] m_data;

  assign flaga_n = model_en ? m_flaga : t_flaga;
  assign fdata_i = model_en ? m_data  : t_data;

  int n_checks;
  int n_fail;

  logic [15:0] fifo[$];
  logic [15:0] rx[$];
  int          pulses;
  logic        rd_pend;

  fx2_ep2_reader dut (
    .clk_fast  (clk_fast),
    .n_rst     (n_rst),
    .fdata_i   (fdata_i),
    .faddr     (faddr),
    .slrd_n    (slrd_n),
    .sloe_n    (sloe_n),
    .flaga_n   (flaga_n),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_cnt  (word_cnt),
    .busy      (busy)
  );

  initial clk_fast = 1'b0;
  always #5 clk_fast = ~clk_fast;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FX2 model and output monitor. A word is popped the negedge after its
  // SLRD pulse was seen, i.e. after the DUT captured it.
  initial begin
    rd_pend = 1'b0;
    pulses  = 0;
    m_flaga = 1'b0;
    m_data  = 16'hDEAD;
  end

  always @(negedge clk_fast) begin
    if (rd_pend && fifo.size() > 0) void'(fifo.pop_front());
    rd_pend = !slrd_n;
    if (!slrd_n) pulses++;
    if (out_valid && out_ready) rx.push_back(out_data);
    check("slrd_low_while_valid", 32'(!slrd_n && out_valid), 32'd0);
    m_flaga = (fifo.size() != 0);
    if (fifo.size() != 0) m_data = fifo[0];
    else                  m_data = 16'hDEAD;
  end

  typedef struct {
    logic        flaga_n;
    logic        bus_gnt;
    logic        out_ready;
    logic [15:0] data;
    logic [4:0]  exp_ctl;    // {bus_req, sloe_n, slrd_n, busy, out_valid}
    logic        chk_data;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic f, input logic g, input logic r, input logic [15:0] d,
                     input logic [4:0] ctl, input logic cd, input logic [15:0] ed);
    vec_t v;
    v.flaga_n = f; v.bus_gnt = g; v.out_ready = r; v.data = d;
    v.exp_ctl = ctl; v.chk_data = cd; v.exp_data = ed;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk_fast);
    n_rst = 1'b0;
    fifo.delete();
    repeat (2) @(negedge clk_fast);
    n_rst = 1'b1;
  endtask

  // Wait until rx holds target words and the FSM is idle; expiry is a failure.
  task automatic wait_rx(input int target, input int budget, input string name);
    int k;
    k = 0;
    while ((rx.size() < target || busy) && k < budget) begin
      @(negedge clk_fast);
      k++;
    end
    check(name, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k;
    k = 0;
    while (!out_valid && k < budget) begin
      @(negedge clk_fast);
      k++;
    end
    check(name, 32'(k < budget), 32'd1);
  endtask

  localparam logic [4:0] C_IDLE  = 5'b01100;
  localparam logic [4:0] C_REQ   = 5'b11110;
  localparam logic [4:0] C_SETUP = 5'b10110;
  localparam logic [4:0] C_RD    = 5'b10010;
  localparam logic [4:0] C_HOLD  = 5'b10111;
  localparam logic [4:0] C_WAITF = 5'b10110;

  initial begin
    int base;
    int p0;
    int acc;
    logic [19:0] exp_cnt;

    n_checks  = 0;
    n_fail    = 0;
    model_en  = 1'b0;
    t_flaga   = 1'b0;
    t_data    = 16'h0000;
    bus_gnt   = 1'b0;
    out_ready = 1'b1;
    n_rst     = 1'b0;

    // Reset values while n_rst is held low.
    #12;
    check("rst_faddr",    32'(faddr),     32'(2'b00));
    check("rst_ctl",      32'({bus_req, sloe_n, slrd_n, busy, out_valid}), 32'(C_IDLE));
    check("rst_out_data", 32'(out_data),  32'h0);
    check("rst_word_cnt", 32'(word_cnt),  32'h0);
    @(negedge clk_fast);
    n_rst = 1'b1;

    // Cycle table: inputs applied at negedge, outputs checked after the next posedge.
    add(0, 0, 1, 16'h0000, C_IDLE,  0, 16'h0000); // empty: stay idle
    add(1, 0, 1, 16'h0000, C_REQ,   0, 16'h0000);
    add(1, 0, 1, 16'h0000, C_REQ,   0, 16'h0000); // no grant: wait in REQ
    add(0, 0, 1, 16'h0000, C_IDLE,  0, 16'h0000); // flag drops in REQ
    add(1, 1, 1, 16'h0000, C_REQ,   0, 16'h0000);
    add(1, 1, 1, 16'h0000, C_SETUP, 0, 16'h0000);
    add(0, 1, 1, 16'h0000, C_IDLE,  0, 16'h0000); // flag drops in SETUP
    add(1, 1, 1, 16'h0000, C_REQ,   0, 16'h0000);
    add(1, 1, 1, 16'h0000, C_SETUP, 0, 16'h0000);
    add(1, 1, 1, 16'h0000, C_RD,    0, 16'h0000);
    add(1, 0, 0, 16'hBEEF, C_HOLD,  1, 16'hBEEF); // grant lost in RD: read completes
    add(1, 0, 0, 16'h1111, C_HOLD,  1, 16'hBEEF); // held stable
    add(1, 0, 1, 16'h1111, C_IDLE,  0, 16'h0000); // delivered, then idle
    add(1, 1, 1, 16'h0000, C_REQ,   0, 16'h0000);
    add(1, 1, 1, 16'h0000, C_SETUP, 0, 16'h0000);
    add(1, 1, 1, 16'h0000, C_RD,    0, 16'h0000);
    add(1, 1, 1, 16'h00FF, C_HOLD,  1, 16'h00FF);
    add(1, 1, 1, 16'h0000, C_WAITF, 0, 16'h0000);
    add(1, 1, 1, 16'h0000, C_RD,    0, 16'h0000); // back-to-back read
    add(1, 1, 1, 16'h5A5A, C_HOLD,  1, 16'h5A5A);
    add(1, 1, 1, 16'h0000, C_WAITF, 0, 16'h0000);
    add(0, 1, 1, 16'h0000, C_IDLE,  0, 16'h0000); // empty after wait
    add(1, 1, 1, 16'h0000, C_REQ,   0, 16'h0000);
    add(1, 1, 1, 16'h0000, C_SETUP, 0, 16'h0000);
    add(1, 0, 1, 16'h0000, C_IDLE,  0, 16'h0000); // grant lost in SETUP

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk_fast);
      t_flaga   = vq[i].flaga_n;
      bus_gnt   = vq[i].bus_gnt;
      out_ready = vq[i].out_ready;
      t_data    = vq[i].data;
      @(posedge clk_fast);
      #1;
      check($sformatf("vec%0d_ctl", i), 32'({bus_req, sloe_n, slrd_n, busy, out_valid}),
            32'(vq[i].exp_ctl));
      if (vq[i].chk_data) check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vq[i].exp_data));
    end

    // Three queued words streamed with grant and ready held high.
    model_en  = 1'b1;
    bus_gnt   = 1'b1;
    out_ready = 1'b1;
    do_reset();
    fifo = '{16'h1234, 16'hABCD, 16'h0001};
    base = rx.size();
    p0   = pulses;
    wait_rx(base + 3, 200, "three_words_timeout");
    repeat (3) @(negedge clk_fast);
    check("three_pulses", 32'(pulses - p0), 32'd3);
    check("word0", 32'(rx[base]),     32'h1234);
    check("word1", 32'(rx[base + 1]), 32'hABCD);
    check("word2", 32'(rx[base + 2]), 32'h0001);
    check("three_cnt", 32'(word_cnt), CNT_EN ? 32'd3 : 32'd0);
    check("three_idle", 32'({busy, sloe_n, bus_req}), 32'b010);

    // Empty FIFO: never requests, never reads.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_fast);
      check("empty_quiet", 32'({bus_req, slrd_n, busy}), 32'b010);
    end

    // Consumer stall after the first word.
    out_ready = 1'b0;
    do_reset();
    fifo = '{16'hC001, 16'hC002};
    base = rx.size();
    wait_valid(50, "stall_valid_timeout");
    p0 = pulses;
    check("stall_first", 32'(out_data), 32'hC001);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_fast);
      check("stall_hold", 32'({out_valid, out_data}), 32'({1'b1, 16'hC001}));
      check("stall_no_read", 32'(pulses), 32'(p0));
    end
    out_ready = 1'b1;
    wait_rx(base + 2, 100, "stall_release_timeout");
    check("stall_second", 32'(rx[base + 1]), 32'hC002);
    check("stall_pulses", 32'(pulses - p0), 32'd1);

    // Grant withdrawn in WAITF after the first word.
    do_reset();
    fifo = '{16'hD001, 16'hD002, 16'hD003};
    base = rx.size();
    p0   = pulses;
    begin
      int k;
      k = 0;
      while (!(out_valid && out_ready) && k < 50) begin
        @(negedge clk_fast);
        k++;
      end
      check("gnt_drop_accept_timeout", 32'(k < 50), 32'd1);
    end
    @(negedge clk_fast);
    bus_gnt = 1'b0;
    @(posedge clk_fast);
    #1;
    check("gnt_drop_idle", 32'({busy, bus_req, sloe_n}), 32'b001);
    repeat (5) @(negedge clk_fast);
    check("gnt_drop_no_read", 32'(pulses - p0), 32'd1);
    bus_gnt = 1'b1;
    wait_rx(base + 3, 200, "regrant_timeout");
    check("regrant_w1", 32'(rx[base + 1]), 32'hD002);
    check("regrant_w2", 32'(rx[base + 2]), 32'hD003);
    check("regrant_pulses", 32'(pulses - p0), 32'd3);

    // Reset while a word is held.
    out_ready = 1'b0;
    do_reset();
    fifo = '{16'hE001, 16'hE002};
    base = rx.size();
    wait_valid(50, "rst_hold_valid_timeout");
    n_rst = 1'b0;
    #1;
    check("rst_hold_ctl", 32'({bus_req, sloe_n, slrd_n, busy, out_valid}), 32'(C_IDLE));
    check("rst_hold_data", 32'(out_data), 32'h0);
    check("rst_hold_faddr", 32'(faddr), 32'(2'b00));
    check("rst_hold_cnt", 32'(word_cnt), 32'h0);
    repeat (2) @(negedge clk_fast);
    out_ready = 1'b1;
    n_rst = 1'b1;
    wait_rx(base + 1, 100, "rst_hold_next_timeout");
    check("rst_hold_next", 32'(rx[base]), 32'hE002);

    // Counter wrap from a forced preload.
    do_reset();
    fifo = '{16'hF001, 16'hF002};
`ifdef FX2_RD_WORDCNT_EN
    force dut.word_cnt = 20'hFFFFE;
    #1;
    release dut.word_cnt;
`endif
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_fast);
      exp_cnt = CNT_EN ? 20'(20'hFFFFE + acc) : 20'd0;
      check("wrap_cnt", 32'(word_cnt), 32'(exp_cnt));
      if (out_valid && out_ready) acc++;
    end
    check("wrap_accepts", 32'(acc), 32'd2);
    check("wrap_final", 32'(word_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
